// File: rtl/gf_mul_16_seq.sv
// Sequential GF(2^16) multiplier over GF(2^8)[X]/(X^2 + X + c).
// A single combinational GF(2^8) multiplier is time-shared across five FSM steps.
module gf_mul_16_seq #(
  parameter logic [7:0] IRRED_CST = 8'h20,
  parameter logic [7:0] GF8_POLY  = 8'h1B
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  output logic        o_busy,
  output logic [15:0] o_o,
  output logic        o_done
);

  localparam int unsigned BW = 8;
  localparam int unsigned WW = 2 * BW;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    S3   = 3'd4,
    S4   = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [WW-1:0]   xr_q, xr_d;
  logic [WW-1:0]   yr_q, yr_d;
  logic [BW-1:0]   acc0_q, acc0_d;
  logic [BW-1:0]   acc1_q, acc1_d;
  logic [BW-1:0]   t_q, t_d;
  logic [WW-1:0]   out_q, out_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  logic [BW-1:0]   mul_a_c, mul_b_c, mul_p_c;

  // Shift-and-add GF(2^8) product, reduced by x^8 + GF8_POLY.
  function automatic logic [BW-1:0] gf8_mul(input logic [BW-1:0] a, input logic [BW-1:0] b);
    logic [BW-1:0] acc;
    logic [BW-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < int'(BW); i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[BW-1] ? ({sh[BW-2:0], 1'b0} ^ GF8_POLY) : {sh[BW-2:0], 1'b0};
    end
    return acc;
  endfunction

  // Operand select for the shared multiplier.
  always_comb begin
    mul_a_c = '0;
    mul_b_c = '0;
    case (state_q)
      S0: begin mul_a_c = xr_q[BW-1:0];  mul_b_c = yr_q[BW-1:0];  end
      S1: begin mul_a_c = xr_q[BW-1:0];  mul_b_c = yr_q[WW-1:BW]; end
      S2: begin mul_a_c = xr_q[WW-1:BW]; mul_b_c = yr_q[BW-1:0];  end
      S3: begin mul_a_c = xr_q[WW-1:BW]; mul_b_c = yr_q[WW-1:BW]; end
      S4: begin mul_a_c = t_q;           mul_b_c = IRRED_CST;     end
      default: ;
    endcase
  end

  assign mul_p_c = gf8_mul(mul_a_c, mul_b_c);

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    acc0_d  = acc0_q;
    acc1_d  = acc1_q;
    t_d     = t_q;
    out_d   = out_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          xr_d    = i_x;
          yr_d    = i_y;
          busy_d  = 1'b1;
          state_d = S0;
        end
      end
      S0: begin
        acc0_d  = mul_p_c;
        state_d = S1;
      end
      S1: begin
        acc1_d  = mul_p_c;
        state_d = S2;
      end
      S2: begin
        acc1_d  = acc1_q ^ mul_p_c;
        state_d = S3;
      end
      S3: begin
        acc1_d  = acc1_q ^ mul_p_c;
        t_d     = mul_p_c;
        state_d = S4;
      end
      S4: begin
        out_d   = {acc1_q, acc0_q ^ mul_p_c};
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      xr_q    <= '0;
      yr_q    <= '0;
      acc0_q  <= '0;
      acc1_q  <= '0;
      t_q     <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      acc0_q  <= acc0_d;
      acc1_q  <= acc1_d;
      t_q     <= t_d;
      out_q   <= out_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign o_busy = busy_q;
  assign o_o    = out_q;
  assign o_done = done_q;

endmodule
